wb_gain_ctrl: RTL and testbench
===============================

WB_GAIN_CTRL -- requirements
Module: wb_gain_ctrl

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 1936: active pixels per line.
REQ-002 SHALL have parameter COL_WIDTH, default 1088: active lines per frame.
REQ-003 SHALL have parameter GAIN_W, default 39: gain width, unsigned, 32 fractional bits (1.0 = 39'd4294967296).
REQ-004 SHALL have port clk  input  1: sole clock; one clock domain, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port per_img_clken  input  1: one valid pixel of the stream this cycle.
REQ-007 SHALL have ports auto_gain_r/g/b  input  GAIN_W each: gains from the statistics estimator.
REQ-008 SHALL have ports cfg_valid input 1, cfg_ready output 1, cfg_we input 1, cfg_addr input 3, cfg_wdata input GAIN_W: host request channel.
REQ-009 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_rdata output GAIN_W: read response channel.
REQ-010 SHALL have ports out_gain_r/g/b  output  GAIN_W each: gains to the gain-apply stage.
REQ-011 SHALL have ports frame_done output 1 (one-cycle pulse on last pixel of a frame), frame_cnt output 16 (completed frames).

Function
REQ-012 Request accepted on cycle with cfg_valid && cfg_ready.
REQ-013 Register map: 0 ctrl (bit0 manual_en, other bits read 0), 1 stg_gain_r, 2 stg_gain_g, 3 stg_gain_b, 4 frame_cnt (read-only, zero-extended); writes to 4..7 ignored; reads of 5..7 return 0.
REQ-014 Handshake FSM states IDLE, RESP: IDLE->RESP on accepted read; RESP->IDLE on rsp_ready; accepted write stays IDLE.
REQ-015 cfg_ready SHALL be 1 in IDLE, 0 in RESP; rsp_valid 1 only in RESP, asserted the cycle after read acceptance.
REQ-016 rsp_rdata SHALL be captured at acceptance and held stable while rsp_valid is high.
REQ-017 Write takes effect in staging registers the cycle after acceptance; staging never drives outputs directly.
REQ-018 Pixel counters col (0..ROW_WIDTH-1), row (0..COL_WIDTH-1) advance only on per_img_clken; col wraps to 0 and increments row; both wrap to 0 after last pixel.
REQ-019 frame_done SHALL pulse the cycle after the clken at col=ROW_WIDTH-1, row=COL_WIDTH-1; frame_cnt increments at the same point, wrapping 65535->0.
REQ-020 At frame end, commit: manual_en=1 -> out_gain_* <= staging; manual_en=0 -> out_gain_* <= auto_gain_* sampled that cycle.
REQ-021 out_gain_* SHALL change only at commit, so gains never change mid-frame.
REQ-022 Write accepted on the commit cycle: commit uses pre-write staging/ctrl; new value applies at the next frame end.
REQ-023 Read of frame_cnt on the increment cycle SHALL return the pre-increment value.

Reset
REQ-024 On rst: FSM IDLE, cfg_ready 1, rsp_valid 0, rsp_rdata 0, manual_en 0, staging gains 1.0, out_gain_* 1.0, col/row 0, frame_done 0, frame_cnt 0.
REQ-025 rst mid-frame or mid-response SHALL abandon the partial frame and any pending response; the next pixel after release is counted as col 0, row 0.

Configuration
REQ-026 Macro WB_GAIN_CLAMP_EN defined: written staging gains above 8.0 (39'd34359738368) SHALL be stored as 8.0; auto gains also clamped at commit.
REQ-027 Macro WB_GAIN_CLAMP_EN undefined: values stored and committed unmodified.

Structure
REQ-028 Shared package SHALL hold register address constants, FSM state type, GAIN_ONE and GAIN_MAX constants.
REQ-029 Sub-module wb_frame_cnt SHALL contain col/row counters and frame_done generation; host FSM and gain registers stay in the top.

Verification
REQ-030 Reset, ROW_WIDTH=4, COL_WIDTH=2, 8 clkens -> frame_done one pulse after 8th, frame_cnt=1, out_gain_*=auto_gain_* sampled then.
REQ-031 Write ctrl=1, gain_r=39'd2147483648 mid-frame -> out_gain_r stays prior value until frame end, then 0.5.
REQ-032 Read addr 1 with rsp_ready held low 5 cycles -> rsp_valid high, rdata stable, cfg_ready low throughout; IDLE one cycle after rsp_ready.
REQ-033 Write gain_g on exact commit cycle -> old value committed; new value committed at following frame end.
REQ-034 WB_GAIN_CLAMP_EN defined, write gain_b=39'd68719476736 (16.0) -> readback and committed gain 39'd34359738368.
REQ-035 Assert rst after 3 of 8 pixels -> frame_cnt 0, out_gain_* 1.0; full frame from col 0 then required for frame_done.

Source files
------------

// File: rtl/wb_gain_ctrl_pkg.sv
// Shared constants and types for the white-balance gain controller.
package wb_gain_ctrl_pkg;

    localparam int unsigned GAIN_BITS = 39;

    // Unsigned gains with 32 fractional bits
    localparam logic [GAIN_BITS-1:0] GAIN_ONE = 39'd4294967296;   // 1.0
    localparam logic [GAIN_BITS-1:0] GAIN_MAX = 39'd34359738368;  // 8.0

    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_GAIN_R    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_GAIN_G    = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_GAIN_B    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FRAME_CNT = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } host_state_e;

endpackage

// File: rtl/wb_frame_cnt.sv
// Pixel position tracking and end-of-frame detection for the gain controller.
module wb_frame_cnt
    import wb_gain_ctrl_pkg::*;
#(
    parameter int unsigned ROW_WIDTH = 1936,
    parameter int unsigned COL_WIDTH = 1088
) (
    input  logic clk,
    input  logic rst,
    input  logic per_img_clken,
    output logic frame_end_c,
    output logic frame_done
);

    localparam int unsigned COL_BITS = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam int unsigned ROW_BITS = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(ROW_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(COL_WIDTH - 1);

    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;

    // Last pixel of the frame is being delivered this cycle
    assign frame_end_c = per_img_clken && (col == COL_LAST) && (row == ROW_LAST);

    // Advance col/row on each valid pixel and register the end-of-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end_c;
            if (per_img_clken) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_BITS'(1);
                end else begin
                    col <= col + COL_BITS'(1);
                end
            end
        end
    end

endmodule

// File: rtl/wb_gain_ctrl.sv
// White-balance gain controller: host register access plus frame-synchronous
// gain commit (manual staging gains or auto gains).
// Optional build macro: WB_GAIN_CLAMP_EN clamps staged and auto gains to 8.0.
module wb_gain_ctrl
    import wb_gain_ctrl_pkg::*;
#(
    parameter int unsigned ROW_WIDTH = 1936,
    parameter int unsigned COL_WIDTH = 1088,
    parameter int unsigned GAIN_W    = 39
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              per_img_clken,
    input  logic [GAIN_W-1:0] auto_gain_r,
    input  logic [GAIN_W-1:0] auto_gain_g,
    input  logic [GAIN_W-1:0] auto_gain_b,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [GAIN_W-1:0] cfg_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [GAIN_W-1:0] rsp_rdata,
    output logic [GAIN_W-1:0] out_gain_r,
    output logic [GAIN_W-1:0] out_gain_g,
    output logic [GAIN_W-1:0] out_gain_b,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam logic [GAIN_W-1:0] GAIN_ONE_W = GAIN_W'(GAIN_ONE);
    localparam logic [GAIN_W-1:0] GAIN_MAX_W = GAIN_W'(GAIN_MAX);

    host_state_e       state;
    logic              manual_en;
    logic [GAIN_W-1:0] stg_gain_r;
    logic [GAIN_W-1:0] stg_gain_g;
    logic [GAIN_W-1:0] stg_gain_b;
    logic [GAIN_W-1:0] read_data_c;
    logic [GAIN_W-1:0] wdata_lim_c;
    logic              accept_c;
    logic              frame_end_c;

    // Saturate a gain at 8.0 when clamping is built in
    function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] g);
`ifdef WB_GAIN_CLAMP_EN
        return (g > GAIN_MAX_W) ? GAIN_MAX_W : g;
`else
        return g;
`endif
    endfunction

    wb_frame_cnt #(
        .ROW_WIDTH (ROW_WIDTH),
        .COL_WIDTH (COL_WIDTH)
    ) u_frame_cnt (
        .clk           (clk),
        .rst           (rst),
        .per_img_clken (per_img_clken),
        .frame_end_c   (frame_end_c),
        .frame_done    (frame_done)
    );

    assign accept_c    = cfg_valid && cfg_ready;
    assign wdata_lim_c = clamp_gain(cfg_wdata);

    // Register read mux, sampled from pre-update state at acceptance
    always_comb begin
        read_data_c = '0;
        case (cfg_addr)
            ADDR_CTRL:      read_data_c = GAIN_W'(manual_en);
            ADDR_GAIN_R:    read_data_c = stg_gain_r;
            ADDR_GAIN_G:    read_data_c = stg_gain_g;
            ADDR_GAIN_B:    read_data_c = stg_gain_b;
            ADDR_FRAME_CNT: read_data_c = GAIN_W'(frame_cnt);
            default:        read_data_c = '0;
        endcase
    end

    // Host handshake FSM: a read parks in RESP until the response is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c && !cfg_we) begin
                        state     <= RESP;
                        cfg_ready <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= read_data_c;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Host writes into ctrl and staging gains; addresses 4..7 are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            manual_en  <= 1'b0;
            stg_gain_r <= GAIN_ONE_W;
            stg_gain_g <= GAIN_ONE_W;
            stg_gain_b <= GAIN_ONE_W;
        end else if (accept_c && cfg_we) begin
            case (cfg_addr)
                ADDR_CTRL:   manual_en  <= cfg_wdata[0];
                ADDR_GAIN_R: stg_gain_r <= wdata_lim_c;
                ADDR_GAIN_G: stg_gain_g <= wdata_lim_c;
                ADDR_GAIN_B: stg_gain_b <= wdata_lim_c;
                default: ;
            endcase
        end
    end

    // Frame-boundary commit of output gains; old staging wins over a same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            out_gain_r <= GAIN_ONE_W;
            out_gain_g <= GAIN_ONE_W;
            out_gain_b <= GAIN_ONE_W;
        end else if (frame_end_c) begin
            if (manual_en) begin
                out_gain_r <= stg_gain_r;
                out_gain_g <= stg_gain_g;
                out_gain_b <= stg_gain_b;
            end else begin
                out_gain_r <= clamp_gain(auto_gain_r);
                out_gain_g <= clamp_gain(auto_gain_g);
                out_gain_b <= clamp_gain(auto_gain_b);
            end
        end
    end

    // Completed-frame counter, free-running modulo 2^16
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_end_c) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_gain_ctrl.sv
// Bench for wb_gain_ctrl: directed scenarios then random traffic, all
// checked cycle by cycle against a frame/register-level reference model.
module tb_wb_gain_ctrl;

    localparam int unsigned GW        = 39;
    localparam int unsigned RW        = 4;
    localparam int unsigned CW        = 2;
    localparam int          FRAME_PIX = RW * CW;

    localparam logic [GW-1:0] ONE  = 39'd4294967296;
    localparam logic [GW-1:0] MAXG = 39'd34359738368;
    localparam logic [GW-1:0] HALF = 39'd2147483648;

    logic          clk = 1'b0;
    logic          rst;
    logic          per_img_clken;
    logic [GW-1:0] auto_gain_r, auto_gain_g, auto_gain_b;
    logic          cfg_valid, cfg_ready, cfg_we;
    logic [2:0]    cfg_addr;
    logic [GW-1:0] cfg_wdata;
    logic          rsp_valid, rsp_ready;
    logic [GW-1:0] rsp_rdata;
    logic [GW-1:0] out_gain_r, out_gain_g, out_gain_b;
    logic          frame_done;
    logic [15:0]   frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit            m_busy;
    logic [GW-1:0] m_rdata;
    bit            m_manual;
    logic [GW-1:0] m_stg [3];
    logic [GW-1:0] m_out [3];
    int            m_pix;
    int            m_fcnt;
    bit            m_fdone;
    logic [GW-1:0] last_auto [3];

    always #5 clk = ~clk;

    wb_gain_ctrl #(
        .ROW_WIDTH (RW),
        .COL_WIDTH (CW),
        .GAIN_W    (GW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .per_img_clken (per_img_clken),
        .auto_gain_r   (auto_gain_r),
        .auto_gain_g   (auto_gain_g),
        .auto_gain_b   (auto_gain_b),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .out_gain_r    (out_gain_r),
        .out_gain_g    (out_gain_g),
        .out_gain_b    (out_gain_b),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [GW-1:0] lim(input logic [GW-1:0] g);
`ifdef WB_GAIN_CLAMP_EN
        return (g > MAXG) ? MAXG : g;
`else
        return g;
`endif
    endfunction

    function automatic logic [GW-1:0] rand_gain();
        case ($urandom_range(0, 3))
            0:       return GW'({$urandom(), $urandom()});
            1:       return ONE;
            default: return GW'($urandom()) + HALF;
        endcase
    endfunction

    function automatic logic [GW-1:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return GW'(m_manual);
            3'd1:    return m_stg[0];
            3'd2:    return m_stg[1];
            3'd3:    return m_stg[2];
            3'd4:    return GW'(m_fcnt);
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_rdata  = '0;
        m_manual = 0;
        m_pix    = 0;
        m_fcnt   = 0;
        m_fdone  = 0;
        for (int k = 0; k < 3; k++) begin
            m_stg[k] = ONE;
            m_out[k] = ONE;
        end
    endtask

    // One clock: drive inputs, advance model across the edge, compare all outputs
    task automatic step(input logic i_clken, input logic i_valid, input logic i_we,
                        input logic [2:0] i_addr, input logic [GW-1:0] i_wdata,
                        input logic i_rdy, input logic i_rst);
        bit            accept;
        bit            n_busy, n_manual;
        logic [GW-1:0] n_rdata;
        logic [GW-1:0] n_stg [3];
        logic [GW-1:0] n_out [3];
        logic [GW-1:0] au [3];
        au[0] = rand_gain();
        au[1] = rand_gain();
        au[2] = rand_gain();
        rst           = i_rst;
        per_img_clken = i_clken;
        cfg_valid     = i_valid;
        cfg_we        = i_we;
        cfg_addr      = i_addr;
        cfg_wdata     = i_wdata;
        rsp_ready     = i_rdy;
        auto_gain_r   = au[0];
        auto_gain_g   = au[1];
        auto_gain_b   = au[2];
        @(posedge clk);
        #1;
        if (i_rst) begin
            model_reset();
        end else begin
            n_busy   = m_busy;
            n_rdata  = m_rdata;
            n_manual = m_manual;
            n_stg    = m_stg;
            n_out    = m_out;
            accept   = i_valid && !m_busy;
            if (m_busy) begin
                if (i_rdy) n_busy = 0;
            end else if (accept && !i_we) begin
                n_busy  = 1;
                n_rdata = model_read(i_addr);
            end
            if (accept && i_we) begin
                if (i_addr == 3'd0) n_manual = i_wdata[0];
                else if (i_addr <= 3'd3) n_stg[i_addr - 3'd1] = lim(i_wdata);
            end
            m_fdone = 0;
            if (i_clken) begin
                if (m_pix == FRAME_PIX - 1) begin
                    m_pix   = 0;
                    m_fdone = 1;
                    m_fcnt  = (m_fcnt + 1) % 65536;
                    for (int k = 0; k < 3; k++) begin
                        n_out[k]     = m_manual ? m_stg[k] : lim(au[k]);
                        last_auto[k] = au[k];
                    end
                end else begin
                    m_pix = m_pix + 1;
                end
            end
            m_busy   = n_busy;
            m_rdata  = n_rdata;
            m_manual = n_manual;
            m_stg    = n_stg;
            m_out    = n_out;
        end
        check_val("cfg_ready",  64'(cfg_ready),  64'(!m_busy));
        check_val("rsp_valid",  64'(rsp_valid),  64'(m_busy));
        check_val("rsp_rdata",  64'(rsp_rdata),  64'(m_rdata));
        check_val("out_gain_r", 64'(out_gain_r), 64'(m_out[0]));
        check_val("out_gain_g", 64'(out_gain_g), 64'(m_out[1]));
        check_val("out_gain_b", 64'(out_gain_b), 64'(m_out[2]));
        check_val("frame_done", 64'(frame_done), 64'(m_fdone));
        check_val("frame_cnt",  64'(frame_cnt),  64'(m_fcnt));
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 3'd0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [GW-1:0] prior_r;
        logic [GW-1:0] gval_a, gval_b;
        rst = 1'b1; per_img_clken = 1'b0; cfg_valid = 1'b0; cfg_we = 1'b0;
        cfg_addr = 3'd0; cfg_wdata = '0; rsp_ready = 1'b0;
        auto_gain_r = '0; auto_gain_g = '0; auto_gain_b = '0;
        model_reset();

        // Reset state
        step(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b1);
        check_val("rst_out_r", 64'(out_gain_r), 64'(ONE));

        // One full 4x2 frame under auto gains
        pixels(FRAME_PIX);
        check_val("f1_done", 64'(frame_done), 64'd1);
        check_val("f1_cnt",  64'(frame_cnt), 64'd1);
        check_val("f1_auto_g", 64'(out_gain_g), 64'(lim(last_auto[1])));
        step(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b1, 1'b0);
        check_val("f1_pulse_end", 64'(frame_done), 64'd0);

        // Manual 0.5 written mid-frame only lands at frame end
        pixels(3);
        prior_r = out_gain_r;
        step(1'b0, 1'b1, 1'b1, 3'd0, 39'd1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'd1, HALF, 1'b1, 1'b0);
        pixels(4);
        check_val("mid_hold_r", 64'(out_gain_r), 64'(prior_r));
        pixels(1);
        check_val("manual_half", 64'(out_gain_r), 64'(HALF));

        // Read held off by rsp_ready low; writes offered meanwhile must be refused
        step(1'b0, 1'b1, 1'b0, 3'd1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 3'd2, GW'(i + 7), 1'b0, 1'b0);
            check_val("held_rdata", 64'(rsp_rdata), 64'(HALF));
        end
        step(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b1, 1'b0);
        check_val("resp_released", 64'(cfg_ready), 64'd1);

        // Write on the exact commit cycle: old staged value committed first
        gval_a = 39'd6442450944;
        gval_b = 39'd1073741824;
        step(1'b0, 1'b1, 1'b1, 3'd2, gval_a, 1'b1, 1'b0);
        pixels(FRAME_PIX - 1);
        step(1'b1, 1'b1, 1'b1, 3'd2, gval_b, 1'b1, 1'b0);
        check_val("commit_old_g", 64'(out_gain_g), 64'(gval_a));
        pixels(FRAME_PIX);
        check_val("commit_new_g", 64'(out_gain_g), 64'(gval_b));

        // Frame counter read on the increment cycle returns the old count
        pixels(FRAME_PIX - 1);
        step(1'b1, 1'b1, 1'b0, 3'd4, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b1, 1'b0);

        // Oversized staged gain (clamped only when built with clamping)
        step(1'b0, 1'b1, 1'b1, 3'd3, 39'd68719476736, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 3'd3, '0, 1'b1, 1'b0);
        check_val("big_b_read", 64'(rsp_rdata), 64'(lim(39'd68719476736)));
        pixels(FRAME_PIX);
        check_val("big_b_commit", 64'(out_gain_b), 64'(lim(39'd68719476736)));

        // Reset mid-frame with a response pending
        pixels(3);
        step(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b1);
        check_val("rst_cnt", 64'(frame_cnt), 64'd0);
        check_val("rst_out_b", 64'(out_gain_b), 64'(ONE));
        pixels(FRAME_PIX - 1);
        check_val("rst_no_early_done", 64'(frame_done), 64'd0);
        pixels(1);
        check_val("rst_full_frame", 64'(frame_done), 64'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [GW-1:0] wd;
            wd = rand_gain();
            if ($urandom_range(0, 7) == 0) wd = GW'($urandom_range(0, 1));
            step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), wd,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
